// File: rtl/pdm_stream_player.sv
// Purpose: stores NUM_CH parallel 1-bit sigma-delta streams and replays them as paced data_out/data_valid strobes.
// Latency: first strobe is two cycles after the edge that samples start; then one strobe every div+1 cycles.
// Backpressure: none; the consumer must accept every strobe. stop aborts at once, start is honoured only in IDLE.
module pdm_stream_player #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 12,
  parameter int DIV_W  = 8,
  parameter int WRAP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [NUM_CH-1:0] wr_data,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W:0]   length,
  input  logic [DIV_W-1:0]  div,
  output logic [NUM_CH-1:0] data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              done,
  output logic [WRAP_W-1:0] wrap_count
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PRIME  = 2'd1,
    S_RUN    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] mem [DEPTH];
  logic [NUM_CH-1:0] rd_data_q;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;

  logic [ADDR_W:0]   len_q, len_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              loop_q, loop_d;
  // index of the word currently sitting in rd_data_q (the next one to be emitted)
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  // completion pending: done is presented one cycle after the deciding event
  logic              fin_q, fin_d;
  logic [NUM_CH-1:0] out_q, out_d;
  logic              vld_q, vld_d;
  logic [WRAP_W-1:0] wrap_q, wrap_d;

  logic              is_last;
  logic [ADDR_W-1:0] next_idx;

  assign is_last  = ({1'b0, idx_q} == (len_q - 1'b1));
  assign next_idx = is_last ? '0 : idx_q + 1'b1;

  // Sample RAM: one write port, one registered read port; a same-edge read sees the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      div_q   <= '0;
      loop_q  <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      fin_q   <= 1'b0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      wrap_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      div_q   <= div_d;
      loop_q  <= loop_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      fin_q   <= fin_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      wrap_q  <= wrap_d;
    end
  end

  // Next-state logic. Each strobe also issues the read of the following word,
  // so with div=0 the RAM stays one word ahead and strobes run back to back.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    div_d   = div_q;
    loop_d  = loop_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    fin_d   = fin_q;
    out_d   = out_q;
    vld_d   = 1'b0;
    wrap_d  = wrap_q;
    rd_en   = 1'b0;
    rd_addr = '0;
    case (state_q)
      S_IDLE: begin
        if (fin_q) begin
          // zero-length request: report completion without replaying anything
          fin_d   = 1'b0;
          state_d = S_FINISH;
        end else if (start && !stop) begin
          if (length != '0) begin
            len_d   = length;
            div_d   = div;
            loop_d  = loop_en;
            wrap_d  = '0;
            idx_d   = '0;
            rd_en   = 1'b1;
            rd_addr = '0;
            state_d = S_PRIME;
          end else begin
            fin_d = 1'b1;
          end
        end
      end
      S_PRIME: begin
        if (stop) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          fin_d   = 1'b0;
          state_d = S_IDLE;
        end else if (fin_q) begin
          fin_d   = 1'b0;
          state_d = S_FINISH;
        end else if (cnt_q == '0) begin
          vld_d   = 1'b1;
          out_d   = rd_data_q;
          rd_en   = 1'b1;
          rd_addr = next_idx;
          idx_d   = next_idx;
          cnt_d   = div_q;
          if (is_last) begin
            if (loop_q) begin
              wrap_d = (&wrap_q) ? wrap_q : wrap_q + 1'b1;
            end else begin
              fin_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign data_out   = out_q;
  assign data_valid = vld_q;
  assign busy       = (state_q == S_PRIME) || (state_q == S_RUN);
  assign done       = (state_q == S_FINISH);
  assign wrap_count = wrap_q;

endmodule

// File: doc/pdm_stream_player.md
Name: pdm_stream_player

Overview:
Synthesizable, parametrised replacement for the file-driven bitstream stimulus used in front of sigma_delta_top. It stores NUM_CH parallel 1-bit sigma-delta streams in an internal RAM and replays them as data_in/data_valid. Replay has programmable pacing (oversampling rate), programmable length, and one-shot or loop mode. It drives one decimator per channel, on-chip or in simulation.

Parameters:
NUM_CH, 2, number of parallel bitstream channels (RAM word width)
ADDR_W, 12, RAM address width; DEPTH = 2**ADDR_W words
DIV_W, 8, width of pacing divider
WRAP_W, 16, width of loop wrap counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
wr_en  in  1  RAM write strobe
wr_addr  in  ADDR_W  RAM write address
wr_data  in  NUM_CH  RAM write data, bit k = channel k
start  in  1  begin replay (single-cycle pulse, sampled in IDLE only)
stop  in  1  abort replay
loop_en  in  1  1 = wrap to address 0 after the last sample
length  in  ADDR_W+1  samples per pass, 0..DEPTH
div  in  DIV_W  valid period = div+1 clocks
data_out  out  NUM_CH  current bit per channel, to decimator data_in
data_valid  out  1  sample strobe, to decimator data_valid
busy  out  1  replay in progress
done  out  1  one-cycle pulse on normal completion
wrap_count  out  WRAP_W  completed passes in loop mode, saturating

Behaviour:
- Reset (async assert, sync deassert in the integrating design): state IDLE. data_out=0, data_valid=0, busy=0, done=0, wrap_count=0, pacing counter=0. RAM contents are not reset.
- RAM: DEPTH x NUM_CH, one write port and one synchronous read port with 1-cycle latency. Writes are accepted in every state.
- Same-address write/read in one cycle: the read returns the old data.
- FSM states: IDLE, PRIME, RUN, FINISH.
- IDLE, start=1, stop=0, length!=0: latch length, div and loop_en. Clear wrap_count. Read address 0. Next state PRIME, busy=1 from the next cycle.
- IDLE, start=1, length=0: no replay. done=1 on the next cycle only. busy stays 0.
- IDLE, start and stop both 1: stop wins and the block remains IDLE.
- start in any state other than IDLE is ignored. Latched length, div and loop_en do not change mid-replay.
- PRIME: one cycle while the RAM read settles. Next state RUN.
- Cycle timing: if start is sampled at edge T, the first data_valid=1 is in the cycle after edge T+2.
- RUN: data_valid=1 for exactly one cycle every div+1 cycles. With div=0 it is held high continuously at one sample per clock with no bubbles, which requires read-ahead addressing.
- data_out updates only when data_valid=1 and holds its value between strobes.
- Sample order within a pass: address 0, 1, ..., length-1.
- Last sample (index length-1) with loop_en=1: the next sample is address 0 with no gap. wrap_count increments in the same cycle that the last sample's data_valid=1, and saturates at all-ones.
- Last sample with loop_en=0: next state FINISH on the cycle after that strobe.
- FINISH: done=1 and busy=0 for one cycle. Then IDLE.
- stop=1 in PRIME or RUN: from the next cycle data_valid=0, busy=0, state IDLE, no done pulse. data_out and wrap_count hold.
- stop=1 on the same cycle as a data_valid strobe: that strobe still completes.
- Reset asserted mid-replay: all outputs clear immediately, with no done pulse. After reset, a new start replays from address 0.
- length=DEPTH is legal: the pass covers the full RAM.

Test Plan:
1. One-shot, continuous pacing.
   - Stimulus: write addresses 0..7 with {ch1,ch0} = 0,1,2,3,0,1,2,3. length=8, div=0, loop_en=0. start at edge T.
   - Required: data_valid high in cycles T+2..T+9. data_out sequence 0,1,2,3,0,1,2,3. done=1 in cycle T+10 only; busy low from T+10.
2. Paced replay.
   - Stimulus: length=4, div=3.
   - Required: data_valid pulses in cycles T+2, T+6, T+10, T+14, each one cycle wide. data_out stable between pulses. done in cycle T+15.
3. Loop mode and stop.
   - Stimulus: length=3, div=0, loop_en=1, run 10 strobes, then stop.
   - Required: data_out sequence 0,1,2,0,1,2,0,1,2,0. wrap_count=3. data_valid=0 and busy=0 the cycle after stop; no done pulse; wrap_count holds 3 until the next start clears it.
4. Zero length and mid-replay start.
   - Stimulus: length=0 start; then, during a separate replay, a second start.
   - Required: zero-length start gives a done pulse at T+1 with no data_valid and busy always 0. The second start during replay is ignored and the sequence is unchanged.
5. start+stop in one cycle, then reset mid-replay.
   - Stimulus: start and stop together in IDLE. Then start a normal replay and assert rst during RUN.
   - Required: the start+stop cycle leaves the block IDLE with no activity. Reset clears all outputs immediately. After release, a fresh start replays from address 0.
6. Full-depth replay with write collision.
   - Stimulus: length=DEPTH. During replay, write the address currently being read.
   - Required: all DEPTH samples are output in order. The colliding read returns the old word, and the new word appears on the next pass (loop_en=1).
